// File: rtl/morse_char_assembler.sv
// Morse character assembler: gathers dot/dash symbols into a letter and
// emits its ASCII code after a letter gap, or a space after a word gap.
module morse_char_assembler #(
  parameter int TICK_FINAL = 4_999_999,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  input  logic       dot,
  input  logic       dash,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic [2:0] sym_count,
  output logic       overflow
);

  localparam int PW =
    (TICK_FINAL > 0) ? $clog2(TICK_FINAL + 1) : 1;
  localparam logic [PW-1:0] PRE_END = PW'(TICK_FINAL);
  localparam logic [3:0] LG_M1 = 4'(LETTER_GAP - 1);
  localparam logic [3:0] WG    = 4'(WORD_GAP);
  localparam logic [3:0] WG_M1 = 4'(WORD_GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WAIT_WORD
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    gap_q, gap_d, gap_inc;
  logic [4:0]    pat_q, pat_d, pat_c;
  logic [2:0]    cnt_q, cnt_d, cnt_c;
  logic          ovf_q, ovf_d, ovf_c;
  logic [7:0]    char_q, char_d, code;
  logic          valid_q, valid_d;
  logic          tick, sym, emit;

  // First symbol sits in the MSB of the used bits of p.
  function automatic logic [7:0] decode(
    input logic [2:0] n,
    input logic [4:0] p
  );
    logic [7:0] c;
    c = 8'h3F;
    case ({n, p})
      {3'd1, 5'b00000}: c = 8'h45;
      {3'd1, 5'b00001}: c = 8'h54;
      {3'd2, 5'b00000}: c = 8'h49;
      {3'd2, 5'b00001}: c = 8'h41;
      {3'd2, 5'b00010}: c = 8'h4E;
      {3'd2, 5'b00011}: c = 8'h4D;
      {3'd3, 5'b00000}: c = 8'h53;
      {3'd3, 5'b00001}: c = 8'h55;
      {3'd3, 5'b00010}: c = 8'h52;
      {3'd3, 5'b00011}: c = 8'h57;
      {3'd3, 5'b00100}: c = 8'h44;
      {3'd3, 5'b00101}: c = 8'h4B;
      {3'd3, 5'b00110}: c = 8'h47;
      {3'd3, 5'b00111}: c = 8'h4F;
      {3'd4, 5'b00000}: c = 8'h48;
      {3'd4, 5'b00001}: c = 8'h56;
      {3'd4, 5'b00010}: c = 8'h46;
      {3'd4, 5'b00100}: c = 8'h4C;
      {3'd4, 5'b00110}: c = 8'h50;
      {3'd4, 5'b00111}: c = 8'h4A;
      {3'd4, 5'b01000}: c = 8'h42;
      {3'd4, 5'b01001}: c = 8'h58;
      {3'd4, 5'b01010}: c = 8'h43;
      {3'd4, 5'b01011}: c = 8'h59;
      {3'd4, 5'b01100}: c = 8'h5A;
      {3'd4, 5'b01101}: c = 8'h51;
      {3'd5, 5'b11111}: c = 8'h30;
      {3'd5, 5'b01111}: c = 8'h31;
      {3'd5, 5'b00111}: c = 8'h32;
      {3'd5, 5'b00011}: c = 8'h33;
      {3'd5, 5'b00001}: c = 8'h34;
      {3'd5, 5'b00000}: c = 8'h35;
      {3'd5, 5'b10000}: c = 8'h36;
      {3'd5, 5'b11000}: c = 8'h37;
      {3'd5, 5'b11100}: c = 8'h38;
      {3'd5, 5'b11110}: c = 8'h39;
      default:          c = 8'h3F;
    endcase
    return c;
  endfunction

  always_comb begin
    pre_d = pre_q + PW'(1);
    if (key || pre_q == PRE_END) pre_d = '0;
  end

  assign tick = !key && (pre_q == PRE_END);
  assign sym  = dot ^ dash;

  // Symbol capture happens first so a same-cycle symbol joins the letter.
  always_comb begin
    pat_c = pat_q;
    cnt_c = cnt_q;
    ovf_c = ovf_q;
    if (sym) begin
      if (cnt_q == 3'd5) begin
        ovf_c = 1'b1;
      end else begin
        pat_c = {pat_q[3:0], dash};
        cnt_c = cnt_q + 3'd1;
      end
    end
  end

  assign gap_inc = (gap_q < WG) ? gap_q + 4'd1 : gap_q;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_c;
    cnt_d   = cnt_c;
    ovf_d   = ovf_c;
    gap_d   = gap_q;
    emit    = 1'b0;
    code    = 8'h00;
    case (state_q)
      IDLE: begin
        gap_d = 4'd0;
        if (sym) state_d = COLLECT;
      end
      COLLECT: begin
        if (sym || key) gap_d = 4'd0;
        else if (tick) gap_d = gap_inc;
        if (tick && gap_q == LG_M1) begin
          emit    = 1'b1;
          code    = ovf_c ? 8'h3F : decode(cnt_c, pat_c);
          pat_d   = 5'd0;
          cnt_d   = 3'd0;
          ovf_d   = 1'b0;
          gap_d   = gap_inc;
          state_d = WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        if (sym || key) begin
          gap_d   = 4'd0;
          state_d = COLLECT;
        end else if (tick) begin
          gap_d = gap_inc;
          if (gap_q == WG_M1) begin
            emit    = 1'b1;
            code    = 8'h20;
            gap_d   = 4'd0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign char_d  = emit ? code : char_q;
  assign valid_d = emit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      gap_q   <= 4'd0;
      pat_q   <= 5'd0;
      cnt_q   <= 3'd0;
      ovf_q   <= 1'b0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      gap_q   <= gap_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      char_q  <= char_d;
      valid_q <= valid_d;
    end
  end

  assign char_out   = char_q;
  assign char_valid = valid_q;
  assign sym_count  = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_morse_char_assembler.sv
// Directed bench for morse_char_assembler with a 10-cycle tick.
module tb_morse_char_assembler;

  logic       clk = 1'b0;
  logic       reset;
  logic       key;
  logic       dot;
  logic       dash;
  logic [7:0] char_out;
  logic       char_valid;
  logic [2:0] sym_count;
  logic       overflow;

  int passed  = 0;
  int failed  = 0;
  int total   = 0;
  int strobes = 0;
  int s0;

  morse_char_assembler #(
    .TICK_FINAL(9),
    .LETTER_GAP(3),
    .WORD_GAP(7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key(key),
    .dot(dot),
    .dash(dash),
    .char_out(char_out),
    .char_valid(char_valid),
    .sym_count(sym_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (char_valid) strobes++;

  task automatic chk(
    input string tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic sym(input logic d, input logic s);
    dot  = d;
    dash = s;
    @(negedge clk);
    dot  = 1'b0;
    dash = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_char(
    input string tag,
    input logic [7:0] exp
  );
    int n;
    n = 0;
    while (!char_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_strobe"}, 8'(char_valid), 8'h01);
    chk(tag, char_out, exp);
    @(negedge clk);
    chk({tag, "_1cyc"}, 8'(char_valid), 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    key   = 1'b0;
    dot   = 1'b0;
    dash  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_char", char_out, 8'h00);
    chk("rst_valid", 8'(char_valid), 8'h00);
    chk("rst_cnt", 8'(sym_count), 8'h00);
    chk("rst_ovf", 8'(overflow), 8'h00);
    reset = 1'b0;

    sym(1'b1, 1'b0);
    chk("A_cnt1", 8'(sym_count), 8'h01);
    sym(1'b0, 1'b1);
    chk("A_cnt2", 8'(sym_count), 8'h02);
    wait_char("A", 8'h41);
    chk("A_cnt0", 8'(sym_count), 8'h00);
    wait_char("A_sp", 8'h20);

    repeat (3) sym(1'b1, 1'b0);
    wait_char("S1", 8'h53);
    repeat (3) sym(1'b0, 1'b1);
    wait_char("O", 8'h4F);
    repeat (3) sym(1'b1, 1'b0);
    wait_char("S2", 8'h53);
    wait_char("SOS_sp", 8'h20);
    s0 = strobes;
    repeat (100) @(negedge clk);
    chk("idle_quiet", 8'(strobes - s0), 8'h00);

    repeat (5) sym(1'b1, 1'b0);
    chk("ov_cnt5", 8'(sym_count), 8'h05);
    chk("ov_pre", 8'(overflow), 8'h00);
    sym(1'b1, 1'b0);
    chk("ov_set", 8'(overflow), 8'h01);
    chk("ov_cnt", 8'(sym_count), 8'h05);
    wait_char("ov_char", 8'h3F);
    chk("ov_clr", 8'(overflow), 8'h00);

    repeat (5) sym(1'b0, 1'b1);
    wait_char("dig0", 8'h30);
    sym(1'b1, 1'b0);
    repeat (4) sym(1'b0, 1'b1);
    wait_char("dig1", 8'h31);
    sym(1'b1, 1'b0);
    sym(1'b0, 1'b1);
    sym(1'b1, 1'b0);
    sym(1'b0, 1'b1);
    sym(1'b1, 1'b0);
    wait_char("unlisted", 8'h3F);
    wait_char("dig_sp", 8'h20);

    sym(1'b1, 1'b0);
    wait_char("E", 8'h45);
    repeat (22) @(negedge clk);
    s0 = strobes;
    key = 1'b1;
    repeat (3) @(negedge clk);
    key = 1'b0;
    sym(1'b0, 1'b1);
    wait_char("T", 8'h54);
    chk("T_nosp", 8'(strobes - s0), 8'h01);

    sym(1'b1, 1'b0);
    sym(1'b1, 1'b0);
    chk("rs_cnt2", 8'(sym_count), 8'h02);
    #2 reset = 1'b1;
    #1;
    chk("rs_char", char_out, 8'h00);
    chk("rs_valid", 8'(char_valid), 8'h00);
    chk("rs_cnt", 8'(sym_count), 8'h00);
    chk("rs_ovf", 8'(overflow), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    s0 = strobes;
    repeat (80) @(negedge clk);
    chk("rs_quiet", 8'(strobes - s0), 8'h00);

    sym(1'b1, 1'b0);
    chk("both_pre", 8'(sym_count), 8'h01);
    sym(1'b1, 1'b1);
    chk("both_cnt", 8'(sym_count), 8'h01);
    wait_char("both_E", 8'h45);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/morse_char_assembler.md
Name: morse_char_assembler

Overview:
- Sits directly downstream of the dot/dash classifier. It consumes the one-cycle dot and dash pulses plus the raw key level.
- It collects up to 5 symbols per letter and measures key-released gaps with an internal 50 ms tick.
- At a letter gap it emits the ASCII character for the buffered pattern; at a word gap it emits an ASCII space.
- Output is a one-cycle char_valid strobe with char_out, intended for a display or UART stage.

Parameters:
- TICK_FINAL, 4_999_999: prescaler terminal count; one tick every TICK_FINAL+1 clk cycles (50 ms at 100 MHz).
- LETTER_GAP, 3: released-key ticks after the last symbol that end a letter.
- WORD_GAP, 7: released-key ticks after the last symbol that end a word; must be greater than LETTER_GAP.

Ports:
- clk, input, 1: system clock; all flops on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- key, input, 1: synchronized key level, 1 = pressed.
- dot, input, 1: one-cycle pulse, one dot recognised.
- dash, input, 1: one-cycle pulse, one dash recognised.
- char_out, output, 8: ASCII code; held until the next emission.
- char_valid, output, 1: one-cycle strobe, char_out is new.
- sym_count, output, 3: symbols buffered for the current letter, 0..5.
- overflow, output, 1: more than 5 symbols were received in the current letter.

Behaviour:
- Reset (async, active-high) forces all outputs and state to zero:
  - char_out=0x00, char_valid=0, sym_count=0, overflow=0.
  - pattern=0, gap_cnt=0, prescaler=0, state IDLE.
- Prescaler:
  - Cleared while key=1.
  - Otherwise counts 0..TICK_FINAL and wraps.
  - tick is high for the one cycle where the count equals TICK_FINAL.
- Symbol capture:
  - dot shifts 0 into the LSB of a 5-bit pattern; dash shifts 1. sym_count increments.
  - dot and dash high in the same cycle: both ignored.
  - A dot/dash while sym_count=5 sets overflow; pattern and sym_count are unchanged.
  - Any dot/dash or key=1 clears gap_cnt.
- gap_cnt:
  - 4 bits, increments on tick while key=0 in COLLECT or WAIT_WORD.
  - Saturates at WORD_GAP.
- States:
  - IDLE: nothing buffered. dot/dash -> COLLECT, symbol captured that cycle.
  - COLLECT: symbols buffered.
    - Tick that brings gap_cnt to LETTER_GAP -> emit the character, clear pattern/sym_count/overflow, go to WAIT_WORD.
  - WAIT_WORD:
    - key=1 or dot/dash -> COLLECT; gap_cnt cleared; a dot/dash is captured as the first symbol of the new letter; no space emitted.
    - Tick that brings gap_cnt to WORD_GAP -> emit 0x20, go to IDLE.
    - Only one space per word; IDLE never emits.
- Emission timing:
  - char_out and char_valid are registered.
  - char_valid is high exactly one cycle, the cycle after the terminating tick.
  - char_out updates on that same edge.
- Lookup, keyed on (sym_count, pattern) with the first symbol in the MSB of the used bits:
  - Standard International Morse for A-Z as 0x41-0x5A and 0-9 as 0x30-0x39.
  - Any unlisted pattern, or overflow=1 at emission, gives 0x3F ('?').
- A symbol arriving on the same cycle as the letter-terminating tick is captured first; the emitted character includes it.
- Reset mid-letter discards the buffered symbols, and no character is emitted.

Test Plan (all with TICK_FINAL=9, LETTER_GAP=3, WORD_GAP=7, i.e. tick every 10 clk):
- dot, then dash, then key=0 for 30 clk -> sym_count goes 1,2, then char_valid for one cycle with char_out=0x41 ('A'), sym_count=0.
- Pulses for "SOS" (...,---,...) with 3-tick gaps between letters, then a 7-tick gap -> strobes 0x53, 0x4F, 0x53, 0x20, and no further strobes while idle.
- Six dots, then a letter gap -> overflow=1 after the 6th dot, sym_count stays 5, char_out=0x3F, then overflow=0.
- Five dashes -> 0x30; dot followed by four dashes -> 0x31; pattern .-.-. (unlisted) -> 0x3F.
- Letter 'E' emitted, then key pressed at tick 5 of the gap and a dash -> no space emitted; the next letter gap gives 0x54 ('T').
- Reset pulsed after two dots -> all outputs 0 immediately (async); a later letter gap yields no strobe; dot and dash in the same cycle -> sym_count unchanged.
